// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - byte-wide core-to-memory bridge with req/ack handshake, stall and timeout abort
module mem_bridge #(
    parameter int                AW         = 8,
    parameter int                DW         = 8,
    parameter int                TIMEOUT    = 15,
    parameter logic [DW-1:0]     ABORT_DATA = 8'hFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_memread,
    input  logic          core_memwrite,
    input  logic [AW-1:0] core_adr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    output logic          core_err,
    input  logic          err_clr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort fires on the REQ cycle whose increment would reach TIMEOUT.
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            err_set;
    logic            core_req;
    logic            timeout_hit;

    assign core_req    = core_memread | core_memwrite;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (core_req) state_d = REQ;
            REQ:  if (mem_ack || timeout_hit) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_stall = 1'b0;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_set    = 1'b0;
        case (state_q)
            IDLE: begin
                core_stall = core_req;
                cnt_d      = '0;
                if (core_req) begin
                    req_d   = 1'b1;
                    we_d    = core_memwrite;
                    adr_d   = core_adr;
                    wdata_d = core_wdata;
                    err_set = core_memread & core_memwrite;
                end
            end
            REQ: begin
                core_stall = 1'b1;
                if (mem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) rdata_d = mem_rdata;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    err_set = 1'b1;
                    if (!we_q) rdata_d = ABORT_DATA;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
        // A new error in the same cycle as err_clr keeps the flag set.
        if (err_set)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
        else              err_d = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign core_rdata = rdata_q;
    assign core_err   = err_q;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_adr    = adr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - directed self-checking bench for mem_bridge
module tb_mem_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       core_memread, core_memwrite;
    logic [7:0] core_adr, core_wdata, core_rdata;
    logic       core_stall, core_err, err_clr;
    logic       mem_req, mem_we;
    logic [7:0] mem_adr, mem_wdata;
    logic       mem_ack;
    logic [7:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    mem_bridge #(.AW(8), .DW(8), .TIMEOUT(15), .ABORT_DATA(8'hFF)) dut (
        .clk           (clk),
        .rst           (rst),
        .core_memread  (core_memread),
        .core_memwrite (core_memwrite),
        .core_adr      (core_adr),
        .core_wdata    (core_wdata),
        .core_rdata    (core_rdata),
        .core_stall    (core_stall),
        .core_err      (core_err),
        .err_clr       (err_clr),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_adr       (mem_adr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // One complete access; ack arrives on REQ cycle number `waits` (0 = first).
    task automatic access(input logic rd, input logic wr, input logic [7:0] adr,
                          input logic [7:0] wd, input int waits,
                          input logic [7:0] ack_data, input bit hold, input string tag);
        core_memread  = rd;
        core_memwrite = wr;
        core_adr      = adr;
        core_wdata    = wd;
        #1;
        check({tag, " idle_stall"}, core_stall, 1);
        check({tag, " idle_req"}, mem_req, 0);
        clk1();
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin
                mem_ack   = 1'b1;
                mem_rdata = ack_data;
            end
            #1;
            check({tag, " req"}, mem_req, 1);
            check({tag, " req_stall"}, core_stall, 1);
            check({tag, " we"}, mem_we, wr);
            check({tag, " adr"}, mem_adr, adr);
            if (wr) check({tag, " wdata"}, mem_wdata, wd);
            clk1();
            mem_ack   = 1'b0;
            mem_rdata = 8'h00;
        end
        #1;
        check({tag, " done_stall"}, core_stall, 0);
        check({tag, " done_req"}, mem_req, 0);
        if (!hold) begin
            core_memread  = 1'b0;
            core_memwrite = 1'b0;
        end
        clk1();
    endtask

    // Read that never gets acked; err_clr optionally raised on the final REQ cycle.
    task automatic timeout_read(input logic [7:0] adr, input bit clr_on_last, input string tag);
        core_memread = 1'b1;
        core_adr     = adr;
        clk1();
        for (int i = 0; i < 15; i++) begin
            if (clr_on_last && i == 14) err_clr = 1'b1;
            #1;
            check({tag, " req"}, mem_req, 1);
            clk1();
            err_clr = 1'b0;
        end
        #1;
        check({tag, " req_drop"}, mem_req, 0);
        check({tag, " stall"}, core_stall, 0);
        check({tag, " abort_data"}, core_rdata, 8'hFF);
        check({tag, " err"}, core_err, 1);
        core_memread = 1'b0;
        clk1();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        core_memread = 1'b0; core_memwrite = 1'b0;
        core_adr = 8'h00; core_wdata = 8'h00;
        err_clr = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
        clk1(); clk1();
        rst = 1'b0;
        #1;
        check("rst mem_req", mem_req, 0);
        check("rst mem_we", mem_we, 0);
        check("rst mem_adr", mem_adr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst core_rdata", core_rdata, 0);
        check("rst core_err", core_err, 0);
        check("rst core_stall", core_stall, 0);
        clk1();

        access(1, 0, 8'h10, 8'h00, 0, 8'hA5, 0, "t1");
        check("t1 rdata", core_rdata, 8'hA5);

        access(0, 1, 8'h20, 8'h3C, 3, 8'hEE, 0, "t2");
        check("t2 rdata_kept", core_rdata, 8'hA5);
        check("t2 err", core_err, 0);

        access(1, 0, 8'h00, 8'h00, 0, 8'h11, 1, "t3a");
        check("t3 rdata0", core_rdata, 8'h11);
        access(1, 0, 8'h01, 8'h00, 0, 8'h22, 1, "t3b");
        check("t3 rdata1", core_rdata, 8'h22);
        access(1, 0, 8'h02, 8'h00, 1, 8'h33, 1, "t3c");
        check("t3 rdata2", core_rdata, 8'h33);
        access(1, 0, 8'h03, 8'h00, 0, 8'h44, 0, "t3d");
        check("t3 rdata3", core_rdata, 8'h44);

        timeout_read(8'h40, 0, "t4");
        clk1();
        mem_ack = 1'b1; mem_rdata = 8'h55;
        clk1();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        #1;
        check("t4 stray_ack_rdata", core_rdata, 8'hFF);
        check("t4 stray_ack_req", mem_req, 0);
        check("t4 stray_ack_stall", core_stall, 0);
        err_clr = 1'b1;
        clk1();
        err_clr = 1'b0;
        #1;
        check("t4 err_cleared", core_err, 0);

        access(1, 1, 8'h50, 8'h66, 0, 8'h99, 0, "t5");
        check("t5 conflict_err", core_err, 1);
        check("t5 rdata_kept", core_rdata, 8'hFF);
        err_clr = 1'b1;
        clk1();
        err_clr = 1'b0;
        #1;
        check("t5 err_cleared", core_err, 0);
        access(1, 0, 8'h51, 8'h00, 14, 8'h5A, 0, "t5ack");
        check("t5 ack_at_limit_rdata", core_rdata, 8'h5A);
        check("t5 ack_at_limit_err", core_err, 0);
        timeout_read(8'h52, 1, "t5race");
        check("t5 race_err", core_err, 1);

        core_memread = 1'b1;
        core_adr     = 8'h70;
        clk1(); clk1();
        rst = 1'b1;
        clk1();
        rst = 1'b0;
        core_memread = 1'b0;
        #1;
        check("t6 req_after_rst", mem_req, 0);
        check("t6 stall_after_rst", core_stall, 0);
        check("t6 rdata_after_rst", core_rdata, 0);
        check("t6 err_after_rst", core_err, 0);
        mem_ack = 1'b1; mem_rdata = 8'h77;
        clk1();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        #1;
        check("t6 stray_rdata", core_rdata, 0);
        check("t6 stray_req", mem_req, 0);
        access(1, 0, 8'h71, 8'h00, 1, 8'h99, 0, "t6post");
        check("t6 post_rdata", core_rdata, 8'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
